// File: rtl/ch2_down_div.sv
// ch2_down_div: synchronous programmable down-counting divider.
// All flops share CLK. A START with a nonzero DIV loads the divisor and
// counts Q from DIV-1 down to 0. Each enabled cycle with Q at 0 reloads Q,
// pulses TC for one cycle and toggles DIV_OUT, so DIV_OUT has period 2N.
module ch2_down_div #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             STOP,
  input  logic             EN,
  input  logic [WIDTH-1:0] DIV,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             DIV_OUT,
  output logic             BUSY
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] divr, divr_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             tc_nxt, div_out_nxt, busy_nxt;
  logic             div_zero;

  // A zero divisor is never latched, so the DIV-1 and DIVR-1 terms below
  // cannot underflow.
  assign div_zero = (DIV == '0);

  // State and output registers; async reset clears everything immediately.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IDLE;
      divr    <= '0;
      Q       <= '0;
      TC      <= 1'b0;
      DIV_OUT <= 1'b0;
      BUSY    <= 1'b0;
    end else begin
      state   <= state_nxt;
      divr    <= divr_nxt;
      Q       <= q_nxt;
      TC      <= tc_nxt;
      DIV_OUT <= div_out_nxt;
      BUSY    <= busy_nxt;
    end
  end

  // Next-state and next-output logic: STOP beats START, START beats EN.
  always_comb begin
    state_nxt   = state;
    divr_nxt    = divr;
    q_nxt       = Q;
    tc_nxt      = 1'b0;
    div_out_nxt = DIV_OUT;
    busy_nxt    = BUSY;
    case (state)
      IDLE: begin
        if (START && !div_zero) begin
          state_nxt = RUN;
          divr_nxt  = DIV;
          q_nxt     = DIV - WIDTH'(1);
          busy_nxt  = 1'b1;
        end
      end
      RUN: begin
        if (STOP || (START && div_zero)) begin
          state_nxt = IDLE;
          q_nxt     = '0;
          busy_nxt  = 1'b0;
        end else if (START) begin
          divr_nxt = DIV;
          q_nxt    = DIV - WIDTH'(1);
        end else if (EN) begin
          if (Q == '0) begin
            q_nxt       = divr - WIDTH'(1);
            tc_nxt      = 1'b1;
            div_out_nxt = ~DIV_OUT;
          end else begin
            q_nxt = Q - WIDTH'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: doc/ch2_down_div.md
Name: ch2_down_div

Overview:
- Synchronous, programmable down-counting frequency divider.
- Complements the ripple up-counter divider in the CH2 set: counts down instead of up, and all flops share one clock instead of rippling.
- Divides CLK by a runtime-selected value N. Produces a one-cycle terminal-count pulse every N enabled cycles and a toggled divided output of period 2N.
- Used as the selectable-rate tick source for CH2 experiments.

Parameters:
- WIDTH, 4, width of the counter and of the divisor input. Maximum divisor is 2^WIDTH-1.

Ports:
- CLK      input   1      system clock; all state updates on the rising edge
- RST_N    input   1      asynchronous active-low reset
- START    input   1      single-cycle pulse; latches DIV and begins counting
- STOP     input   1      single-cycle pulse; halts counting and returns to idle
- EN       input   1      count enable; when low, the count holds
- DIV      input   WIDTH  divisor N, sampled only on START
- Q        output  WIDTH  current count value (registered)
- TC       output  1      terminal-count pulse (registered)
- DIV_OUT  output  1      divided clock, toggles on every TC event (registered)
- BUSY     output  1      high while in the RUN state (registered)

Behaviour:
- Interface: one clock, CLK. Reset RST_N is asynchronous and active-low.
- Reset (RST_N=0, takes effect immediately, no clock edge needed):
  - state=IDLE, DIVR=0, Q=0, TC=0, DIV_OUT=0, BUSY=0.
- States: IDLE and RUN. DIVR is an internal WIDTH-bit divisor register.
- IDLE:
  - START=1 and DIV!=0: DIVR<=DIV, Q<=DIV-1, BUSY<=1, go to RUN.
  - START=1 and DIV==0: ignored; stay in IDLE, all outputs unchanged.
  - STOP in IDLE: no effect.
  - TC is 0 in IDLE. Q holds its value.
- RUN, priority order at each edge:
  1. STOP=1: go to IDLE; Q<=0, TC<=0, BUSY<=0, DIV_OUT holds. STOP beats a simultaneous START or EN.
  2. START=1: restart.
     - DIV!=0: DIVR<=DIV, Q<=DIV-1, TC<=0, DIV_OUT holds, stay in RUN.
     - DIV==0: behave as STOP.
  3. EN=1 and Q==0: Q<=DIVR-1 (wrap/reload), TC<=1, DIV_OUT<=~DIV_OUT.
  4. EN=1 and Q!=0: Q<=Q-1, TC<=0.
  5. EN=0: Q holds, TC<=0, DIV_OUT holds.
- Timing with EN held high and divisor N:
  - TC is high for exactly one cycle in every N.
  - TC is high in the same cycle that Q shows N-1 after a reload.
  - DIV_OUT has period 2N with 50% duty.
  - The first TC occurs N cycles after the START edge.
- N=1: Q stays at 0, TC is high continuously, DIV_OUT toggles every cycle (CLK/2).
- Arithmetic:
  - Q decrements modulo nothing: it never goes below 0; it reloads from DIVR-1.
  - DIV-1 and DIVR-1 are computed at WIDTH bits. They are never evaluated with a zero divisor, because zero divisors are rejected on START.
- DIV changes while in RUN have no effect until the next START.
- Reset asserted mid-RUN aborts immediately to the reset values. Counting resumes only after RST_N=1 and a new START.
- No X propagation: every register has a defined reset value.

Test Plan:
- Reset, then START with DIV=5, EN=1 throughout:
  - Q sequence after START is 4,3,2,1,0,4,3,...
  - TC=1 exactly when Q returns to 4.
  - DIV_OUT toggles every 5 cycles (period 10).
  - BUSY=1.
- START with DIV=1, EN=1: Q=0 constantly, TC=1 every cycle, DIV_OUT alternates 0,1,0,1 on successive cycles.
- START with DIV=0 from IDLE: BUSY stays 0, Q=0, TC=0, DIV_OUT unchanged for 10 cycles.
- DIV=3 running, EN=0 for 2 cycles while Q=1:
  - Q holds at 1, TC=0 during the hold.
  - With EN=1 again, Q goes 0, then 2 with TC=1.
  - Total TC spacing is 5 cycles.
- In RUN with DIV=4, assert START (DIV=7) and STOP in the same cycle: next cycle state=IDLE, Q=0, BUSY=0, TC=0, DIV_OUT unchanged. A later START with DIV=7 gives Q=6.
- DIV=2 running with DIV_OUT=1, drive RST_N low between clock edges:
  - Q, TC, DIV_OUT and BUSY all go to 0 immediately, without a clock edge.
  - They stay 0 after RST_N releases until START.
